// File: rtl/aes_round_engine_if.sv
// aes_round_engine_if
//   Bundles every signal between the AES round engine, the mode controller
//   that feeds it, and the round-key store.
//
//   Handshake: a block moves on a rising edge where valid and ready are both
//   high. A source keeps valid and its data stable until that edge. A sink
//   may drive ready without waiting for valid. The engine's in_ready depends
//   only on its own state and out_ready, and never on in_valid.
//
//   Signals:
//     in_valid / in_ready / plaintext    : input block handshake
//     out_valid / out_ready / ciphertext : result handshake
//     rk_idx / round_key                 : round-key lookup; the key store
//                                          answers in the same cycle
//     busy                               : engine is in ROUND or FINAL
//     state_dbg                          : raw FSM state encoding
//   Modports: slave = engine side, master = controller / key-store side.
interface aes_round_engine_if #(
    parameter int RK_IDX_W = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [127:0]        plaintext;
    logic [RK_IDX_W-1:0] rk_idx;
    logic [127:0]        round_key;
    logic                out_valid;
    logic                out_ready;
    logic [127:0]        ciphertext;
    logic                busy;
    logic [1:0]          state_dbg;

    modport slave (
        input  in_valid, plaintext, round_key, out_ready,
        output in_ready, rk_idx, out_valid, ciphertext, busy, state_dbg
    );

    modport master (
        output in_valid, plaintext, round_key, out_ready,
        input  in_ready, rk_idx, out_valid, ciphertext, busy, state_dbg
    );
endinterface

// File: rtl/aes_round_engine.sv
// aes_round_engine
//   Iterative AES encryption core. A single round datapath (SubBytes,
//   ShiftRows, MixColumns, AddRoundKey) is reused over NR cycles. The last
//   round skips MixColumns. Round keys come from an external store that is
//   addressed by bus.rk_idx and answers combinationally on bus.round_key.
//
//   Parameters: KEY_BITS (128/192/256 -> NR = 10/12/14), RK_IDX_W.
//   Ports: clk, rst (synchronous, active-high) and bus (aes_round_engine_if.slave).
//   Byte order: bits [127:120] hold s[0][0], and the rest follow column-major.
//
//   Optional build macro AES_SBOX_REG_EN puts a register after SubBytes.
//   ROUND and FINAL then take two cycles each. Phase 0 latches SubBytes.
//   Phase 1 samples round_key and finishes the round.
module aes_round_engine #(
    parameter int KEY_BITS = 128,
    parameter int RK_IDX_W = 4
) (
    input logic              clk,
    input logic              rst,
    aes_round_engine_if.slave bus
);
    localparam int NR = (KEY_BITS == 128) ? 10 :
                        (KEY_BITS == 192) ? 12 :
                        (KEY_BITS == 256) ? 14 : 0;

    generate
        if (NR == 0) begin : g_bad_key_bits
            $error("aes_round_engine: KEY_BITS must be 128, 192 or 256");
        end
        if ((1 << RK_IDX_W) <= NR) begin : g_bad_rk_idx_w
            $error("aes_round_engine: RK_IDX_W too narrow for NR");
        end
    endgenerate

    localparam logic [RK_IDX_W-1:0] LAST_RND  = RK_IDX_W'(NR - 1);
    localparam logic [RK_IDX_W-1:0] FINAL_IDX = RK_IDX_W'(NR);
    localparam logic [RK_IDX_W-1:0] FIRST_RND = RK_IDX_W'(1);

    // FIPS-197 forward S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = SBOX[s[127-8*k -: 8]];
        return r;
    endfunction

    // Byte k sits at row k%4 and column k/4. Row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int row = 0; row < 4; row++) begin
            for (int col = 0; col < 4; col++) begin
                r[127-8*(row+4*col) -: 8] = s[127-8*(row+4*((col+row)%4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int col = 0; col < 4; col++) begin
            a0 = s[127-32*col -: 8];
            a1 = s[119-32*col -: 8];
            a2 = s[111-32*col -: 8];
            a3 = s[103-32*col -: 8];
            r[127-32*col -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*col -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*col -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*col -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    state_t              state_q, state_d;
    logic [RK_IDX_W-1:0] rnd_q, rnd_d;
    logic [127:0]        st_q, st_d;
    logic [127:0]        ct_q, ct_d;
    logic [127:0]        sb_now, sb_use, sr, mc;
    logic [RK_IDX_W-1:0] rk_idx_c;
    logic                in_ready_c, out_valid_c;
    logic                adv;   // high in the cycle that finishes a round

    assign sb_now = sub_bytes(st_q);

`ifdef AES_SBOX_REG_EN
    logic         phase_q, phase_d;
    logic [127:0] sb_q, sb_d;
    assign sb_use = sb_q;
    assign adv    = phase_q;
`else
    assign sb_use = sb_now;
    assign adv    = 1'b1;
`endif

    assign sr = shift_rows(sb_use);
    assign mc = mix_columns(sr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            st_q    <= '0;
            ct_q    <= '0;
`ifdef AES_SBOX_REG_EN
            phase_q <= 1'b0;
            sb_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            st_q    <= st_d;
            ct_q    <= ct_d;
`ifdef AES_SBOX_REG_EN
            phase_q <= phase_d;
            sb_q    <= sb_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        st_d        = st_q;
        ct_d        = ct_q;
        rk_idx_c    = '0;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
`ifdef AES_SBOX_REG_EN
        phase_d = phase_q;
        sb_d    = sb_q;
        if (state_q == ROUND || state_q == FINAL) begin
            phase_d = ~phase_q;
            if (!phase_q) sb_d = sb_now;
        end
`endif
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    st_d    = bus.plaintext ^ bus.round_key;
                    rnd_d   = FIRST_RND;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                rk_idx_c = rnd_q;
                if (adv) begin
                    st_d  = mc ^ bus.round_key;
                    rnd_d = rnd_q + 1'b1;
                    if (rnd_q == LAST_RND) state_d = FINAL;
                end
            end
            FINAL: begin
                rk_idx_c = FINAL_IDX;
                if (adv) begin
                    ct_d    = sr ^ bus.round_key;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                in_ready_c  = bus.out_ready;
                // rk_idx is 0 here, so round_key already holds the whitening
                // key when a new block is taken on the same edge as the transfer.
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        st_d    = bus.plaintext ^ bus.round_key;
                        rnd_d   = FIRST_RND;
                        state_d = ROUND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.rk_idx     = rk_idx_c;
    assign bus.ciphertext = ct_q;
    assign bus.busy       = (state_q == ROUND) || (state_q == FINAL);
    assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_aes_round_engine.sv
// tb_aes_round_engine
//   Runs AES-128, AES-192 and AES-256 engines side by side from one shared
//   handshake sequence. A bench-side key expansion fills each key store.
//   Expected ciphertexts are the FIPS-197 example vectors.
module tb_aes_round_engine;
    localparam logic [127:0] PT_A   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

    localparam logic [0:255][7:0] SBOX_TB = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUTs and key stores ----------------
    aes_round_engine_if #(.RK_IDX_W(4)) if128 ();
    aes_round_engine_if #(.RK_IDX_W(4)) if192 ();
    aes_round_engine_if #(.RK_IDX_W(4)) if256 ();

    aes_round_engine #(.KEY_BITS(128), .RK_IDX_W(4)) dut128 (.clk(clk), .rst(rst), .bus(if128));
    aes_round_engine #(.KEY_BITS(192), .RK_IDX_W(4)) dut192 (.clk(clk), .rst(rst), .bus(if192));
    aes_round_engine #(.KEY_BITS(256), .RK_IDX_W(4)) dut256 (.clk(clk), .rst(rst), .bus(if256));

    logic         in_valid;
    logic         out_ready;
    logic [127:0] pt128;
    logic [127:0] pt_x;
    int           key_sel;
    logic [127:0] rk_tab [4][16];   // 0: C.1 key, 1: appendix-B key, 2: 192, 3: 256

    assign if128.in_valid  = in_valid;
    assign if192.in_valid  = in_valid;
    assign if256.in_valid  = in_valid;
    assign if128.out_ready = out_ready;
    assign if192.out_ready = out_ready;
    assign if256.out_ready = out_ready;
    assign if128.plaintext = pt128;
    assign if192.plaintext = pt_x;
    assign if256.plaintext = pt_x;
    assign if128.round_key = rk_tab[key_sel][if128.rk_idx];
    assign if192.round_key = rk_tab[2][if192.rk_idx];
    assign if256.round_key = rk_tab[3][if256.rk_idx];

    logic         ov [3];
    logic         ir [3];
    logic         bz [3];
    logic [3:0]   rk [3];
    logic [127:0] ct [3];
    assign ov[0] = if128.out_valid;  assign ov[1] = if192.out_valid;  assign ov[2] = if256.out_valid;
    assign ir[0] = if128.in_ready;   assign ir[1] = if192.in_ready;   assign ir[2] = if256.in_ready;
    assign bz[0] = if128.busy;       assign bz[1] = if192.busy;       assign bz[2] = if256.busy;
    assign rk[0] = if128.rk_idx;     assign rk[1] = if192.rk_idx;     assign rk[2] = if256.rk_idx;
    assign ct[0] = if128.ciphertext; assign ct[1] = if192.ciphertext; assign ct[2] = if256.ciphertext;

    int           nr_of [3] = '{10, 12, 14};
    logic [127:0] ct_exp [3];

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input int inst, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, inst, obs, exp);
        end
    endtask

    // ---------------- key schedule model ----------------
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX_TB[w[31:24]], SBOX_TB[w[23:16]], SBOX_TB[w[15:8]], SBOX_TB[w[7:0]]};
    endfunction

    task automatic expand(input int t, input logic [255:0] key, input int nk);
        logic [31:0] w [64];
        logic [31:0] tmp;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 64; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int r = 0; r < 16; r++)
            rk_tab[t][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic check_idle(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_out_valid"},  i, 128'(ov[i]), 128'(0));
            chk({tag, "_in_ready"},   i, 128'(ir[i]), 128'(1));
            chk({tag, "_busy"},       i, 128'(bz[i]), 128'(0));
            chk({tag, "_rk_idx"},     i, 128'(rk[i]), 128'(0));
            chk({tag, "_ciphertext"}, i, ct[i],       128'(0));
        end
    endtask

    // Called at a negedge with the engines in IDLE or DONE; returns just
    // after the accepting edge.
    task automatic accept();
        in_valid = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("accept_in_ready", i, 128'(ir[i]), 128'(1));
            chk("accept_rk_idx",   i, 128'(rk[i]), 128'(0));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Follows the engines for ncyc cycles after an accept; cycle c is sampled
    // at the c-th negedge. Optionally toggles inputs while all are busy.
    task automatic watch(input int ncyc, input bit junk);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                int n;
                n = nr_of[i];
                chk("rk_idx",    i, 128'(rk[i]), 128'((c <= n) ? c : 0));
                chk("busy",      i, 128'(bz[i]), 128'(c <= n));
                chk("out_valid", i, 128'(ov[i]), 128'(out_ready ? (c == n + 1) : (c > n)));
                chk("in_ready",  i, 128'(ir[i]), 128'((c > n) && out_ready));
                if (c == n + 1 || (c > n && !out_ready))
                    chk("ciphertext", i, ct[i], ct_exp[i]);
            end
            if (junk) begin
                if (c >= 2 && c <= 8) begin
                    in_valid = 1'($urandom_range(0, 1));
                    pt128    = {$urandom(), $urandom(), $urandom(), $urandom()};
                    pt_x     = {$urandom(), $urandom(), $urandom(), $urandom()};
                end else if (c == 9) begin
                    in_valid = 1'b0;
                end
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pt128     = PT_A;
        pt_x      = PT_A;
        key_sel   = 0;
        expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        expand(1, {KEY_B, 128'h0}, 4);
        expand(2, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
        expand(3, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("reset");

        // FIPS-197 C.1/C.2/C.3 blocks with junk on the inputs while busy, then
        // 20 extra cycles of backpressure on the AES-128 result.
        ct_exp[0] = CT_128;
        ct_exp[1] = CT_192;
        ct_exp[2] = CT_256;
        accept();
        watch(31, 1'b1);

        // Release backpressure and offer the next block on the same edge.
        // The AES-128 engine moves to the appendix-B key and block.
        key_sel   = 1;
        pt128     = PT_B;
        pt_x      = PT_A;
        out_ready = 1'b1;
        accept();
        ct_exp[0] = CT_B;
        watch(16, 1'b0);

        // Reset while round 5 is in flight, then a fresh C.1 block.
        key_sel   = 0;
        pt128     = PT_A;
        ct_exp[0] = CT_128;
        accept();
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) chk("round5_rk_idx", i, 128'(rk[i]), 128'(5));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("mid_reset");
        accept();
        watch(16, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
